// File: rtl/soc1_ram_fill_check.sv
// Avalon-MM master that fills a word range of the on-chip RAM with a constant or incrementing
// pattern, checks a range against that pattern, or does both, reporting mismatches.
module soc1_ram_fill_check #(
    parameter int unsigned ADDR_W       = 15,
    parameter int unsigned DEPTH        = 25000,
    parameter int unsigned READ_LATENCY = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [1:0]        cmd_mode,
    input  logic [ADDR_W-1:0] cmd_base,
    input  logic [15:0]       cmd_count,
    input  logic [31:0]       cmd_pattern,
    input  logic              cmd_incr,
    output logic              busy,
    output logic              done,
    output logic [15:0]       err_count,
    output logic              err_flag,
    output logic [ADDR_W-1:0] first_err_addr,
    output logic [ADDR_W-1:0] address,
    output logic              chipselect,
    output logic              write,
    output logic [3:0]        byteenable,
    output logic [31:0]       writedata,
    input  logic [31:0]       readdata,
    input  logic              waitrequest
);

    typedef enum logic [2:0] {StIdle, StWr, StRdReq, StRdWait, StFin} state_e;

    localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(DEPTH - 1);
    localparam logic [2:0]        LatInit  = 3'(READ_LATENCY);

    state_e            state_q, state_d;
    logic              chk_after_q, chk_after_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [15:0]       count_q, count_d;
    logic [31:0]       pattern_q, pattern_d;
    logic              incr_q, incr_d;
    logic [15:0]       idx_q, idx_d;
    logic [2:0]        lat_q, lat_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [15:0]       err_count_q, err_count_d;
    logic              err_flag_q, err_flag_d;
    logic [ADDR_W-1:0] first_err_q, first_err_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              cs_q, cs_d;
    logic              wr_q, wr_d;
    logic [31:0]       wdata_q, wdata_d;

    logic [15:0]       idx_inc;
    logic              is_last;
    logic [ADDR_W-1:0] addr_inc;
    logic [31:0]       exp_data;
    logic [31:0]       next_data;

    always_comb begin
        state_d     = state_q;
        chk_after_d = chk_after_q;
        base_d      = base_q;
        count_d     = count_q;
        pattern_d   = pattern_q;
        incr_d      = incr_q;
        idx_d       = idx_q;
        lat_d       = lat_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        err_count_d = err_count_q;
        first_err_d = first_err_q;
        addr_d      = addr_q;
        cs_d        = cs_q;
        wr_d        = wr_q;
        wdata_d     = wdata_q;

        idx_inc   = idx_q + 16'd1;
        is_last   = (idx_inc == count_q);
        addr_inc  = (addr_q == LastAddr) ? '0 : addr_q + ADDR_W'(1);
        exp_data  = incr_q ? pattern_q + {16'd0, idx_q} : pattern_q;
        next_data = incr_q ? pattern_q + {16'd0, idx_inc} : pattern_q;

        unique case (state_q)
            StIdle: begin
                if (start && (cmd_mode != 2'b00)) begin
                    chk_after_d = cmd_mode[1] & cmd_mode[0];
                    base_d      = cmd_base;
                    count_d     = cmd_count;
                    pattern_d   = cmd_pattern;
                    incr_d      = cmd_incr;
                    idx_d       = '0;
                    addr_d      = cmd_base;
                    busy_d      = 1'b1;
                    err_count_d = '0;
                    first_err_d = '0;
                    if (cmd_count == 16'd0) begin
                        state_d = StFin;
                    end else if (cmd_mode[0]) begin
                        state_d = StWr;
                        cs_d    = 1'b1;
                        wr_d    = 1'b1;
                        wdata_d = cmd_pattern;
                    end else begin
                        state_d = StRdReq;
                        cs_d    = 1'b1;
                        wr_d    = 1'b0;
                    end
                end
            end
            StWr: begin
                if (!waitrequest) begin
                    if (!is_last) begin
                        idx_d   = idx_inc;
                        addr_d  = addr_inc;
                        wdata_d = next_data;
                    end else if (chk_after_d) begin
                        // Fill done: rewind to the base and read the same range back.
                        state_d = StRdReq;
                        idx_d   = '0;
                        addr_d  = base_q;
                        wr_d    = 1'b0;
                    end else begin
                        state_d = StFin;
                        cs_d    = 1'b0;
                        wr_d    = 1'b0;
                    end
                end
            end
            StRdReq: begin
                if (!waitrequest) begin
                    state_d = StRdWait;
                    cs_d    = 1'b0;
                    lat_d   = LatInit;
                end
            end
            StRdWait: begin
                lat_d = lat_q - 3'd1;
                if (lat_q == 3'd1) begin
                    if (readdata != exp_data) begin
                        if (err_count_q != 16'hFFFF) begin
                            err_count_d = err_count_q + 16'd1;
                        end
                        if (err_count_q == 16'd0) begin
                            first_err_d = addr_q;
                        end
                    end
                    if (is_last) begin
                        state_d = StFin;
                    end else begin
                        state_d = StRdReq;
                        cs_d    = 1'b1;
                        idx_d   = idx_inc;
                        addr_d  = addr_inc;
                    end
                end
            end
            StFin: begin
                state_d = StIdle;
                busy_d  = 1'b0;
                done_d  = 1'b1;
            end
            default: state_d = StIdle;
        endcase

        err_flag_d = (err_count_d != 16'd0);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            chk_after_q <= 1'b0;
            base_q      <= '0;
            count_q     <= '0;
            pattern_q   <= '0;
            incr_q      <= 1'b0;
            idx_q       <= '0;
            lat_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_count_q <= '0;
            err_flag_q  <= 1'b0;
            first_err_q <= '0;
            addr_q      <= '0;
            cs_q        <= 1'b0;
            wr_q        <= 1'b0;
            wdata_q     <= '0;
        end else begin
            state_q     <= state_d;
            chk_after_q <= chk_after_d;
            base_q      <= base_d;
            count_q     <= count_d;
            pattern_q   <= pattern_d;
            incr_q      <= incr_d;
            idx_q       <= idx_d;
            lat_q       <= lat_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_count_q <= err_count_d;
            err_flag_q  <= err_flag_d;
            first_err_q <= first_err_d;
            addr_q      <= addr_d;
            cs_q        <= cs_d;
            wr_q        <= wr_d;
            wdata_q     <= wdata_d;
        end
    end

    assign busy           = busy_q;
    assign done           = done_q;
    assign err_count      = err_count_q;
    assign err_flag       = err_flag_q;
    assign first_err_addr = first_err_q;
    assign address        = addr_q;
    assign chipselect     = cs_q;
    assign write          = wr_q;
    assign writedata      = wdata_q;
    assign byteenable     = cs_q ? 4'hF : 4'h0;

endmodule

// File: tb/tb_soc1_ram_fill_check.sv
// Bench for soc1_ram_fill_check: Avalon RAM slave model, reference memory model and a
// scoreboard that checks every bus transfer and every completion.
module tb_soc1_ram_fill_check;

    localparam int unsigned ADDR_W = 15;
    localparam int unsigned DEPTH  = 25000;
    localparam int unsigned LAT    = 1;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              start = 1'b0;
    logic [1:0]        cmd_mode = '0;
    logic [ADDR_W-1:0] cmd_base = '0;
    logic [15:0]       cmd_count = '0;
    logic [31:0]       cmd_pattern = '0;
    logic              cmd_incr = 1'b0;
    logic              busy, done, err_flag, chipselect, write;
    logic [15:0]       err_count;
    logic [ADDR_W-1:0] first_err_addr, address;
    logic [3:0]        byteenable;
    logic [31:0]       writedata;
    logic [31:0]       readdata = '0;
    logic              waitrequest = 1'b0;

    soc1_ram_fill_check #(
        .ADDR_W      (ADDR_W),
        .DEPTH       (DEPTH),
        .READ_LATENCY(LAT)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .cmd_mode      (cmd_mode),
        .cmd_base      (cmd_base),
        .cmd_count     (cmd_count),
        .cmd_pattern   (cmd_pattern),
        .cmd_incr      (cmd_incr),
        .busy          (busy),
        .done          (done),
        .err_count     (err_count),
        .err_flag      (err_flag),
        .first_err_addr(first_err_addr),
        .address       (address),
        .chipselect    (chipselect),
        .write         (write),
        .byteenable    (byteenable),
        .writedata     (writedata),
        .readdata      (readdata),
        .waitrequest   (waitrequest)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int done_cnt = 0;
    int done_cyc = 0;
    int d0       = 0;
    int start_cyc = 0;
    logic force_wait = 1'b0;
    logic rand_en    = 1'b0;
    logic cs_seen    = 1'b0;
    logic              corrupt_req  = 1'b0;
    logic [ADDR_W-1:0] corrupt_addr = '0;
    logic [31:0]       corrupt_val  = '0;

    logic [31:0]       ref_mem [DEPTH];
    logic [31:0]       mem [DEPTH];
    logic [ADDR_W-1:0] wr_addr_q [$];
    logic [31:0]       wr_data_q [$];
    logic [ADDR_W-1:0] rd_q [$];
    logic [15:0]       err_q [$];
    logic [ADDR_W-1:0] first_q [$];

    function automatic void chk(input string name, input logic [63:0] act,
                                input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endfunction

    // Cycle counter, shared time base for latency measurements.
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial forever begin
        @(posedge clk);
        #2;
        waitrequest = force_wait || (rand_en && ($urandom_range(0, 3) == 0));
    end

    // Ideal RAM slave with one-cycle read latency; corrupt_req pokes a word behind the master.
    initial begin
        for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
        forever begin
            @(posedge clk);
            if (corrupt_req) begin
                mem[corrupt_addr] <= corrupt_val;
            end else if (chipselect && !waitrequest && (int'(address) < int'(DEPTH))) begin
                if (write) mem[address] <= writedata;
                else       readdata <= mem[address];
            end
        end
    end

    // Monitor: pops the scoreboard on every accepted transfer and every done pulse.
    logic              stall_prev = 1'b0;
    logic [ADDR_W-1:0] snap_addr;
    logic [31:0]       snap_data;
    logic              snap_wr;
    initial forever begin
        @(negedge clk);
        if (reset) begin
            stall_prev = 1'b0;
        end else begin
            if (chipselect) cs_seen = 1'b1;
            if (stall_prev) begin
                chk("stall_address", 64'(address), 64'(snap_addr));
                chk("stall_writedata", 64'(writedata), 64'(snap_data));
                chk("stall_write", 64'(write), 64'(snap_wr));
                chk("stall_chipselect", 64'(chipselect), 64'd1);
            end
            stall_prev = chipselect && waitrequest;
            snap_addr  = address;
            snap_data  = writedata;
            snap_wr    = write;
            if (chipselect && !waitrequest) begin
                chk("byteenable", 64'(byteenable), 64'hF);
                if (write) begin
                    chk("write_expected", 64'(wr_addr_q.size() != 0), 64'd1);
                    if (wr_addr_q.size() != 0) begin
                        chk("wr_addr", 64'(address), 64'(wr_addr_q.pop_front()));
                        chk("wr_data", 64'(writedata), 64'(wr_data_q.pop_front()));
                    end
                end else begin
                    chk("read_expected", 64'(rd_q.size() != 0), 64'd1);
                    if (rd_q.size() != 0) chk("rd_addr", 64'(address), 64'(rd_q.pop_front()));
                end
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
                chk("done_busy_low", 64'(busy), 64'd0);
                chk("done_expected", 64'(err_q.size() != 0), 64'd1);
                if (err_q.size() != 0) begin
                    logic [15:0] e;
                    e = err_q.pop_front();
                    chk("err_count", 64'(err_count), 64'(e));
                    chk("err_flag", 64'(err_flag), 64'(e != 16'd0));
                    chk("first_err_addr", 64'(first_err_addr), 64'(first_q.pop_front()));
                end
            end
        end
    end

    function automatic int word_addr(input int base, input int i);
        return (base + i) % int'(DEPTH);
    endfunction

    function automatic logic [31:0] word_data(input logic [31:0] pat, input logic incr,
                                              input int i);
        return incr ? pat + 32'(i) : pat;
    endfunction

    // Reference model: predicts the bus traffic and result of a command, then issues it.
    task automatic issue(input logic [1:0] mode, input int base, input int count,
                         input logic [31:0] pat, input logic incr);
        int errs;
        int first;
        errs  = 0;
        first = 0;
        if (mode != 2'b00) begin
            if (mode[0]) begin
                for (int i = 0; i < count; i++) begin
                    wr_addr_q.push_back(ADDR_W'(word_addr(base, i)));
                    wr_data_q.push_back(word_data(pat, incr, i));
                    ref_mem[word_addr(base, i)] = word_data(pat, incr, i);
                end
            end
            if (mode[1]) begin
                for (int i = 0; i < count; i++) begin
                    rd_q.push_back(ADDR_W'(word_addr(base, i)));
                    if (ref_mem[word_addr(base, i)] != word_data(pat, incr, i)) begin
                        if (errs == 0) first = word_addr(base, i);
                        errs++;
                    end
                end
            end
            err_q.push_back(errs > 65535 ? 16'hFFFF : 16'(errs));
            first_q.push_back(ADDR_W'(first));
        end
        d0          = done_cnt;
        cmd_mode    = mode;
        cmd_base    = ADDR_W'(base);
        cmd_count   = 16'(count);
        cmd_pattern = pat;
        cmd_incr    = incr;
        start       = 1'b1;
        @(posedge clk);
        #1;
        start     = 1'b0;
        start_cyc = cyc;
        if (mode != 2'b00) chk("busy_rise", 64'(busy), 64'd1);
    endtask

    // exp_lat: cycle (1 = first cycle after the start edge) in which done is expected; <0 skips.
    task automatic wait_done(input int exp_lat);
        while (done_cnt == d0 && (cyc - start_cyc) < 3000) begin
            @(posedge clk);
            #1;
        end
        chk("done_seen", 64'(done_cnt - d0), 64'd1);
        if (done_cnt != d0 && exp_lat >= 0)
            chk("done_latency", 64'(done_cyc - start_cyc + 1), 64'(exp_lat));
        chk("idle_busy_low", 64'(busy), 64'd0);
    endtask

    task automatic corrupt(input int a, input logic [31:0] v);
        corrupt_addr = ADDR_W'(a);
        corrupt_val  = v;
        corrupt_req  = 1'b1;
        @(posedge clk);
        #1;
        corrupt_req = 1'b0;
        ref_mem[a]  = v;
    endtask

    initial begin
        for (int i = 0; i < int'(DEPTH); i++) ref_mem[i] = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_chipselect", 64'(chipselect), 64'd0);
        chk("rst_write", 64'(write), 64'd0);
        chk("rst_byteenable", 64'(byteenable), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_err_count", 64'(err_count), 64'd0);
        chk("rst_err_flag", 64'(err_flag), 64'd0);
        chk("rst_first_err", 64'(first_err_addr), 64'd0);
        chk("rst_address", 64'(address), 64'd0);
        chk("rst_writedata", 64'(writedata), 64'd0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Plain incrementing fill, one word per clock.
        issue(2'b01, 0, 4, 32'hA5A5_0000, 1'b1);
        wait_done(6);
        // Fill then check across the DEPTH-1 -> 0 wrap.
        issue(2'b11, 24998, 4, 32'h1, 1'b0);
        wait_done(14);
        // Single corrupted word inside a checked range.
        issue(2'b01, 3, 5, 32'h0, 1'b1);
        wait_done(7);
        corrupt(5, 32'hDEAD);
        issue(2'b10, 3, 5, 32'h0, 1'b1);
        wait_done(12);

        // Three stalled cycles on the second write.
        issue(2'b01, 200, 4, 32'h1234_0000, 1'b1);
        @(posedge clk);
        #1;
        force_wait = 1'b1;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        force_wait = 1'b0;
        wait_done(9);

        // Zero-length command: done two cycles after start, no bus cycle.
        cs_seen = 1'b0;
        issue(2'b01, 10, 0, 32'hFFFF_FFFF, 1'b0);
        wait_done(2);
        chk("count0_no_cs", 64'(cs_seen), 64'd0);

        // Mode 00 is a no-op.
        issue(2'b00, 400, 3, 32'h1, 1'b0);
        repeat (5) @(posedge clk);
        #1;
        chk("mode00_no_done", 64'(done_cnt - d0), 64'd0);
        chk("mode00_not_busy", 64'(busy), 64'd0);

        // A second start while busy must not disturb the running fill.
        issue(2'b01, 300, 6, 32'h5555_0000, 1'b0);
        @(posedge clk);
        #1;
        cmd_mode  = 2'b10;
        cmd_base  = '0;
        cmd_count = 16'd3;
        start     = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(8);
        repeat (4) @(posedge clk);
        #1;
        chk("busy_start_one_done", 64'(done_cnt - d0), 64'd1);

        // Reset after two accepted writes of an 8-word fill.
        issue(2'b01, 100, 8, 32'hC0DE_0000, 1'b1);
        for (int g = 0; g < 50 && wr_addr_q.size() > 6; g++) begin
            @(posedge clk);
            #1;
        end
        reset      = 1'b1;
        force_wait = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_mid_cs_low", 64'(chipselect), 64'd0);
        chk("rst_mid_busy_low", 64'(busy), 64'd0);
        reset      = 1'b0;
        force_wait = 1'b0;
        wr_addr_q.delete();
        wr_data_q.delete();
        rd_q.delete();
        err_q.delete();
        first_q.delete();
        for (int i = 0; i < 8; i++) ref_mem[word_addr(100, i)] = (i < 2) ? 32'hC0DE_0000 + 32'(i) : 32'h0;
        repeat (4) @(posedge clk);
        #1;
        chk("rst_mid_no_done", 64'(done_cnt - d0), 64'd0);
        // Two words survive, the third was never written.
        issue(2'b10, 100, 3, 32'hC0DE_0000, 1'b1);
        wait_done(8);

        // Randomized fill/check pairs with random stalls and corruptions.
        rand_en = 1'b1;
        for (int k = 0; k < 14; k++) begin
            int b;
            int n;
            logic [31:0] p;
            logic inc;
            b   = int'($urandom_range(0, DEPTH - 1));
            n   = int'($urandom_range(0, 10));
            p   = $urandom();
            inc = 1'($urandom_range(0, 1));
            issue(($urandom_range(0, 1) == 1) ? 2'b11 : 2'b01, b, n, p, inc);
            wait_done(-1);
            if (n != 0 && $urandom_range(0, 1) == 1)
                corrupt(word_addr(b, int'($urandom_range(0, n - 1))), $urandom());
            if (n != 0 && $urandom_range(0, 3) == 0) corrupt(word_addr(b, 0), $urandom());
            issue(2'b10, b, n, p, inc);
            wait_done(-1);
        end
        rand_en = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("wr_q_drained", 64'(wr_addr_q.size()), 64'd0);
        chk("rd_q_drained", 64'(rd_q.size()), 64'd0);
        chk("res_q_drained", 64'(err_q.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/soc1_ram_fill_check.md
Name: soc1_ram_fill_check

Overview:
- Avalon-MM master (initiator) that drives the word-addressed 32-bit on-chip RAM slave port: address, byteenable, chipselect, write, writedata and readdata.
- On command it fills a word range with a constant or incrementing pattern, checks a range against that pattern, or does both.
- Reports busy, a done pulse, a mismatch count and the first failing address.
- Used by the game logic / CPU side to clear the board memory and self-test it.

Parameters:
- ADDR_W, 15, word address width driven to the slave.
- DEPTH, 25000, number of words in the slave; addresses wrap DEPTH-1 -> 0.
- READ_LATENCY, 1, cycles from read acceptance to valid readdata (1..4).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  command strobe, sampled only in IDLE.
- cmd_mode  in  2  01 fill, 10 check, 11 fill then check, 00 no-op.
- cmd_base  in  ADDR_W  first word address; must be < DEPTH.
- cmd_count  in  16  number of words; 0 is legal.
- cmd_pattern  in  32  pattern seed.
- cmd_incr  in  1  1: expected/written data = pattern + word index (mod 2^32); 0: constant.
- busy  out  1  high from the cycle after accepted start until done.
- done  out  1  one-cycle pulse at command completion.
- err_count  out  16  mismatches in last check; saturates at 16'hFFFF.
- err_flag  out  1  err_count != 0.
- first_err_addr  out  ADDR_W  address of first mismatch; 0 if none.
- address  out  ADDR_W  Avalon word address.
- chipselect  out  1  transfer request.
- write  out  1  1 write, 0 read (when chipselect).
- byteenable  out  4  always 4'b1111 when chipselect, else 0.
- writedata  out  32  write data.
- readdata  in  32  read data from slave.
- waitrequest  in  1  slave stall; tie 0 for direct RAM connection.

Behaviour:
- Reset: every output is 0; state is IDLE; internal counters are cleared. Reset has priority over all inputs and takes effect mid-command; chipselect is low the next cycle. Any partial fill stays in RAM.
- States: IDLE, WR, RD_REQ, RD_WAIT, FIN.
- Command capture (IDLE): start=1 with mode != 00 latches all cmd_* inputs and clears err_count, err_flag and first_err_addr. busy rises the next cycle.
  - Mode 01 or 11: go to WR. Mode 10: go to RD_REQ.
  - cmd_count = 0: go directly to FIN; no bus cycle is issued.
- start while busy, or mode 00: ignored; no done pulse.
- Index and address: index runs from 0 to count-1. address = base + index, wrapping DEPTH-1 -> 0.
- Data: data = cmd_incr ? pattern + index : pattern, truncated to 32 bits.
- WR state:
  - Drive chipselect=1, write=1, address and writedata for the current index.
  - A transfer is accepted on a cycle where waitrequest=0. All master outputs are held stable while waitrequest=1.
  - Each accepted write advances the index; with waitrequest=0, throughput is 1 word/clk.
  - After the last accept: mode 01 goes to FIN; mode 11 resets the index to 0 and goes to RD_REQ.
- RD_REQ state: drive chipselect=1, write=0. On accept, go to RD_WAIT with a latency counter set to READ_LATENCY.
- RD_WAIT state:
  - chipselect=0 while waiting. readdata is sampled exactly READ_LATENCY cycles after the accept cycle and compared with the expected data.
  - On mismatch: err_count increments (saturating). first_err_addr is loaded only if err_count was 0.
  - Then the index advances. The next state is RD_REQ, or FIN after the last word.
  - Read throughput: 1 word per READ_LATENCY+1 cycles (non-pipelined).
- FIN state: done=1 for one cycle, busy=0 from that same cycle, return to IDLE. Error outputs hold until the next accepted start.
- A start in the FIN cycle is ignored; it is accepted only in IDLE.
- err_flag is registered; it updates in the same cycle as err_count.

Test Plan:
- Fill: reset, start mode=01 base=0 count=4 pattern=32'hA5A5_0000 incr=1, waitrequest=0.
  -> Writes at addresses 0..3 with data A5A50000..A5A50003 on 4 consecutive cycles; done pulses once; busy low after.
- Fill+check on an ideal RAM model: mode=11 base=24998 count=4 pattern=32'h1 incr=0.
  -> Addresses 24998, 24999, 0, 1 are written, then read back; err_count=0, err_flag=0.
- Mismatch: model corrupts word 5 to 32'hDEAD; check mode=10 base=3 count=5 incr=1 pattern=0.
  -> err_count=1, first_err_addr=5, err_flag=1.
- Stall: waitrequest=1 for 3 cycles on the 2nd write.
  -> address, writedata, write and chipselect stay stable; 4 words are written with no duplicate and no skip.
- Edge commands:
  - count=0 -> done 2 cycles after start, with no chipselect.
  - start during busy -> ignored.
  - mode=00 -> no done pulse.
- Reset mid-fill after 2 words -> chipselect=0 and busy=0 next cycle; no done pulse; a new start works normally.
